meas_seq_ctrl: RTL and testbench

MEAS_SEQ_CTRL -- requirements
Module: meas_seq_ctrl

---
 rtl/meas_pkg.sv | 43 ++++
 rtl/meas_regfile.sv | 87 ++++++++
 rtl/meas_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_meas_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared definitions for the measurement sequencer: register map, CTRL bits,
// FSM state encoding and the configuration bundle.
package meas_pkg;

  localparam int unsigned A_CTRL      = 0;
  localparam int unsigned A_MODE      = 1;
  localparam int unsigned A_NPTS      = 2;
  localparam int unsigned A_BIN_WIDTH = 3;
  localparam int unsigned A_BIN_NUM   = 4;
  localparam int unsigned A_BIN_MIN   = 5;
  localparam int unsigned A_STATUS    = 6;
  localparam int unsigned A_COUNT     = 7;

  localparam int CTRL_START      = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_CLEAR_DONE = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_ACQ   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [1:0]  analyze_mode;
    logic        output_mode;
    logic [15:0] npts;
    logic [31:0] bin_width;
    logic [15:0] bin_num;
    logic [31:0] bin_min;
  } cfg_t;

  typedef struct packed {
    logic start;
    logic abort;
    logic clear_done;
  } ctrl_t;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_CLEAR) || (st == ST_ARM) || (st == ST_ACQ);
  endfunction

endpackage

// File: rtl/meas_regfile.sv
// HVI register file: configuration registers, CTRL strobe decode, sticky
// error flag and registered read-back of status and point count.
module meas_regfile
  import meas_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] hvi_addr,
  input  logic              hvi_wr_en,
  input  logic              hvi_rd_en,
  input  logic [DATA_W-1:0] hvi_wr_data,
  output logic [DATA_W-1:0] hvi_rd_data,
  input  logic [2:0]        state,
  input  logic [15:0]       count,
  output cfg_t              cfg,
  output ctrl_t             ctrl
);

  logic              busy;
  logic              err;
  logic              ctrl_wr;
  logic              cfg_wr;
  logic [DATA_W-1:0] rd_mux;

  assign busy    = is_busy(state);
  assign ctrl_wr = hvi_wr_en && (hvi_addr == ADDR_W'(A_CTRL));
  assign cfg_wr  = hvi_wr_en && (hvi_addr >= ADDR_W'(A_MODE)) && (hvi_addr <= ADDR_W'(A_BIN_MIN));

  // CTRL is write-only and self-clearing: its bits only exist as one-cycle strobes.
  assign ctrl.abort      = ctrl_wr && hvi_wr_data[CTRL_ABORT];
  assign ctrl.start      = ctrl_wr && hvi_wr_data[CTRL_START] && !hvi_wr_data[CTRL_ABORT];
  assign ctrl.clear_done = ctrl_wr && hvi_wr_data[CTRL_CLEAR_DONE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg <= '0;
    end else if (cfg_wr && !busy) begin
      case (hvi_addr)
        ADDR_W'(A_MODE): begin
          cfg.analyze_mode <= hvi_wr_data[1:0];
          cfg.output_mode  <= hvi_wr_data[4];
        end
        ADDR_W'(A_NPTS):      cfg.npts      <= hvi_wr_data[15:0];
        ADDR_W'(A_BIN_WIDTH): cfg.bin_width <= hvi_wr_data[31:0];
        ADDR_W'(A_BIN_NUM):   cfg.bin_num   <= hvi_wr_data[15:0];
        ADDR_W'(A_BIN_MIN):   cfg.bin_min   <= hvi_wr_data[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ctrl.clear_done) begin
      err <= 1'b0;
    end else if (busy && (cfg_wr || ctrl.start)) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (hvi_addr)
      ADDR_W'(A_MODE):      rd_mux = DATA_W'({cfg.output_mode, 2'b00, cfg.analyze_mode});
      ADDR_W'(A_NPTS):      rd_mux = DATA_W'(cfg.npts);
      ADDR_W'(A_BIN_WIDTH): rd_mux = DATA_W'(cfg.bin_width);
      ADDR_W'(A_BIN_NUM):   rd_mux = DATA_W'(cfg.bin_num);
      ADDR_W'(A_BIN_MIN):   rd_mux = DATA_W'(cfg.bin_min);
      ADDR_W'(A_STATUS):    rd_mux = DATA_W'({err, state == ST_DONE, 1'b0, state});
      ADDR_W'(A_COUNT):     rd_mux = DATA_W'(count);
      default:              rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hvi_rd_data <= '0;
    end else if (hvi_rd_en) begin
      hvi_rd_data <= rd_mux;
    end
  end

endmodule

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: clears the analysis engine, arms on a trigger edge,
// gates acquisition of NPTS I/Q points and reports completion.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle engine clear pulse
// ARM   | waiting for trigger rising edge
// ACQ   | engine accepting data, counting iq_valid
// DONE  | shot complete, done held until start or clear_done
module meas_seq_ctrl
  import meas_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] hvi_addr,
  input  logic              hvi_wr_en,
  input  logic              hvi_rd_en,
  input  logic [DATA_W-1:0] hvi_wr_data,
  output logic [DATA_W-1:0] hvi_rd_data,
  input  logic              trigger,
  input  logic              iq_valid,
  output logic [1:0]        analyze_mode,
  output logic              output_mode,
  output logic [15:0]       num_data_pts,
  output logic [31:0]       bin_width,
  output logic [31:0]       bin_min,
  output logic [15:0]       bin_num,
  output logic              acq_en,
  output logic              acq_clear,
  output logic              busy,
  output logic              done
);

  logic [2:0]  state;
  logic [15:0] count;
  logic        trigger_q;
  cfg_t        cfg;
  ctrl_t       ctrl;

  meas_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .hvi_addr    (hvi_addr),
    .hvi_wr_en   (hvi_wr_en),
    .hvi_rd_en   (hvi_rd_en),
    .hvi_wr_data (hvi_wr_data),
    .hvi_rd_data (hvi_rd_data),
    .state       (state),
    .count       (count),
    .cfg         (cfg),
    .ctrl        (ctrl)
  );

  assign analyze_mode = cfg.analyze_mode;
  assign output_mode  = cfg.output_mode;
  assign num_data_pts = cfg.npts;
  assign bin_width    = cfg.bin_width;
  assign bin_min      = cfg.bin_min;
  assign bin_num      = cfg.bin_num;

  // Outputs are decoded from the state register so reset clears them at once.
  assign acq_en    = (state == ST_ACQ);
  assign acq_clear = (state == ST_CLEAR);
  assign busy      = is_busy(state);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= trigger;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (ctrl.abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.start) begin
            state <= ST_CLEAR;
            count <= '0;
          end
        end
        ST_CLEAR: begin
          state <= (cfg.npts == 16'd0) ? ST_DONE : ST_ARM;
        end
        ST_ARM: begin
          if (trigger && !trigger_q) begin
            state <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (iq_valid) begin
            count <= count + 16'd1;
            if (count + 16'd1 == cfg.npts) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (ctrl.start) begin
            state <= ST_CLEAR;
            count <= '0;
          end else if (ctrl.clear_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Directed bench for meas_seq_ctrl: register access, shot sequencing,
// busy-write protection, abort, trigger edge qualification and reset.
module tb_meas_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hvi_addr = '0;
  logic        hvi_wr_en = 1'b0;
  logic        hvi_rd_en = 1'b0;
  logic [31:0] hvi_wr_data = '0;
  logic [31:0] hvi_rd_data;
  logic        trigger = 1'b0;
  logic        iq_valid = 1'b0;
  logic [1:0]  analyze_mode;
  logic        output_mode;
  logic [15:0] num_data_pts;
  logic [31:0] bin_width;
  logic [31:0] bin_min;
  logic [15:0] bin_num;
  logic        acq_en;
  logic        acq_clear;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int clr_cycles = 0;
  int acq_cycles = 0;
  int snap;
  logic [31:0] rd;

  meas_seq_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .hvi_addr     (hvi_addr),
    .hvi_wr_en    (hvi_wr_en),
    .hvi_rd_en    (hvi_rd_en),
    .hvi_wr_data  (hvi_wr_data),
    .hvi_rd_data  (hvi_rd_data),
    .trigger      (trigger),
    .iq_valid     (iq_valid),
    .analyze_mode (analyze_mode),
    .output_mode  (output_mode),
    .num_data_pts (num_data_pts),
    .bin_width    (bin_width),
    .bin_min      (bin_min),
    .bin_num      (bin_num),
    .acq_en       (acq_en),
    .acq_clear    (acq_clear),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (acq_clear === 1'b1) clr_cycles++;
    if (acq_en === 1'b1) acq_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    hvi_addr = a; hvi_wr_data = d; hvi_wr_en = 1'b1;
    step(1);
    hvi_wr_en = 1'b0;
  endtask

  task automatic rdreg(input logic [9:0] a, output logic [31:0] d);
    hvi_addr = a; hvi_rd_en = 1'b1;
    step(1);
    hvi_rd_en = 1'b0;
    d = hvi_rd_data;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_outputs", {acq_en, acq_clear, busy, done, output_mode, analyze_mode}, 32'h0);
    chk("rst_cfg", {num_data_pts, bin_num}, 32'h0);
    chk("rst_rd_data", hvi_rd_data, 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    rdreg(10'd6, rd); chk("status_after_rst", rd, 32'h0);

    // configuration registers and readback
    wr(10'd1, 32'h0000_0012);
    chk("analyze_mode", {30'b0, analyze_mode}, 32'd2);
    chk("output_mode", {31'b0, output_mode}, 32'd1);
    wr(10'd2, 32'd4);
    wr(10'd3, 32'h0003_0002);
    wr(10'd4, 32'h0000_0810);
    wr(10'd5, 32'hFFF0_0010);
    chk("num_data_pts", {16'b0, num_data_pts}, 32'd4);
    chk("bin_width", bin_width, 32'h0003_0002);
    chk("bin_num", {16'b0, bin_num}, 32'h0810);
    chk("bin_min", bin_min, 32'hFFF0_0010);
    rdreg(10'd1, rd); chk("rd_mode", rd, 32'h12);
    rdreg(10'd5, rd); chk("rd_bin_min", rd, 32'hFFF0_0010);
    rdreg(10'd0, rd); chk("rd_ctrl_zero", rd, 32'h0);
    rdreg(10'd9, rd); chk("rd_unmapped_zero", rd, 32'h0);
    wr(10'd6, 32'hFFFF_FFFF);
    wr(10'd7, 32'hFFFF_FFFF);
    rdreg(10'd6, rd); chk("status_ro", rd, 32'h0);
    rdreg(10'd7, rd); chk("count_ro", rd, 32'h0);

    // normal shot, NPTS=4
    snap = clr_cycles;
    wr(10'd0, 32'h1);
    chk("clear_pulse_on", {30'b0, acq_clear, busy}, 32'b11);
    step(1);
    chk("clear_pulse_off", {31'b0, acq_clear}, 32'd0);
    rdreg(10'd6, rd); chk("status_arm", rd, 32'h2);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    chk("acq_en_after_trig", {31'b0, acq_en}, 32'd1);
    iq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("acq_en_mid", {30'b0, acq_en, done}, 32'b10);
    end
    step(1);
    iq_valid = 1'b0;
    chk("acq_en_after_last", {29'b0, acq_en, busy, done}, 32'b001);
    chk("clear_pulse_count", clr_cycles - snap, 32'd1);
    rdreg(10'd7, rd); chk("count_4", rd, 32'd4);
    rdreg(10'd6, rd); chk("status_done", rd, 32'h14);
    iq_valid = 1'b1;
    step(2);
    iq_valid = 1'b0;
    rdreg(10'd7, rd); chk("count_hold_done", rd, 32'd4);

    // NPTS=0 shot
    wr(10'd2, 32'd0);
    snap = acq_cycles;
    wr(10'd0, 32'h1);
    chk("npts0_clear", {31'b0, acq_clear}, 32'd1);
    step(1);
    chk("npts0_done", {31'b0, done}, 32'd1);
    rdreg(10'd7, rd); chk("npts0_count", rd, 32'd0);
    chk("npts0_no_acq", acq_cycles - snap, 32'd0);

    // busy-write protection and err flag
    wr(10'd0, 32'h4);
    chk("clear_done_idle", {30'b0, busy, done}, 32'b00);
    wr(10'd2, 32'd4);
    wr(10'd0, 32'h1);
    step(1);
    wr(10'd4, 32'h0000_0A10);
    chk("bin_num_kept", {16'b0, bin_num}, 32'h0810);
    rdreg(10'd4, rd); chk("rd_bin_num_kept", rd, 32'h0810);
    rdreg(10'd6, rd); chk("status_err", rd, 32'h22);
    wr(10'd0, 32'h4);
    rdreg(10'd6, rd); chk("status_err_cleared", rd, 32'h02);
    wr(10'd0, 32'h1);
    rdreg(10'd6, rd); chk("status_start_busy_err", rd, 32'h22);
    wr(10'd0, 32'h2);
    rdreg(10'd6, rd); chk("status_abort_arm", rd, 32'h20);
    wr(10'd0, 32'h4);
    rdreg(10'd6, rd); chk("status_all_clear", rd, 32'h00);

    // abort mid-acquisition
    wr(10'd2, 32'd8);
    wr(10'd0, 32'h1);
    step(1);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    iq_valid = 1'b1;
    step(3);
    iq_valid = 1'b0;
    wr(10'd0, 32'h2);
    chk("abort_idle", {29'b0, acq_en, busy, done}, 32'b000);
    rdreg(10'd7, rd); chk("abort_count", rd, 32'd3);
    iq_valid = 1'b1;
    step(3);
    iq_valid = 1'b0;
    rdreg(10'd7, rd); chk("idle_valid_ignored", rd, 32'd3);
    wr(10'd0, 32'h3);
    chk("abort_beats_start", {31'b0, busy}, 32'd0);

    // trigger already high before start
    trigger = 1'b1;
    wr(10'd2, 32'd2);
    wr(10'd0, 32'h1);
    step(5);
    chk("held_trig_no_acq", {30'b0, acq_en, busy}, 32'b01);
    trigger = 1'b0;
    step(1);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    chk("retrig_acq", {31'b0, acq_en}, 32'd1);
    rdreg(10'd2, rd); chk("rd_npts_acq", rd, 32'd2);
    iq_valid = 1'b1;
    step(1);
    iq_valid = 1'b0;
    chk("still_acq", {31'b0, acq_en}, 32'd1);

    // reset mid-shot
    snap = clr_cycles;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ctl_outputs", {28'b0, acq_en, acq_clear, busy, done}, 32'h0);
    chk("rst_mode_npts", {13'b0, output_mode, analyze_mode, num_data_pts}, 32'h0);
    chk("rst_bins", bin_width | bin_min | {16'b0, bin_num}, 32'h0);
    chk("rst_rd_data_mid", hvi_rd_data, 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_no_clear_pulse", clr_cycles - snap, 32'd0);
    rdreg(10'd6, rd); chk("rst_status", rd, 32'h0);
    rdreg(10'd7, rd); chk("rst_count", rd, 32'h0);
    rdreg(10'd2, rd); chk("rst_npts_rd", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
